// File: rtl/message_slicer_fifo_if.sv
// Handshake bundle for message_slicer_fifo: wide-word toggle-strobe input, narrow valid/ready output.
// out_last exists only when MESSAGE_SLICER_FIFO_LAST_EN is defined.
interface message_slicer_fifo_if #(
    parameter int N_SLICES          = 2,
    parameter int LOG_N_SLICES      = 1,
    parameter int WIDTH             = 32,
    parameter int LOG_BUFFER_LENGTH = 5
);
    logic [WIDTH*N_SLICES-1:0]  in_data;
    logic [LOG_N_SLICES:0]      in_len;
    logic                       in_nd;
    logic [WIDTH-1:0]           out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [LOG_BUFFER_LENGTH:0] fill_count;
    logic                       error;
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
    logic                       out_last;
`endif

    modport master (
        output in_data, in_len, in_nd, out_ready,
        input  out_data, out_valid, fill_count, error
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
        , input out_last
`endif
    );

    modport slave (
        input  in_data, in_len, in_nd, out_ready,
        output out_data, out_valid, fill_count, error
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
        , output out_last
`endif
    );
endinterface

// File: rtl/message_slicer_fifo.sv
// Buffered serialiser: wide words enter a FIFO on a toggle strobe and leave one WIDTH slice per beat.
// Optional end-of-word flag out_last is enabled by defining MESSAGE_SLICER_FIFO_LAST_EN.
module message_slicer_fifo #(
    parameter int N_SLICES          = 2,
    parameter int LOG_N_SLICES      = 1,
    parameter int WIDTH             = 32,
    parameter int BUFFER_LENGTH     = 32,
    parameter int LOG_BUFFER_LENGTH = 5
) (
    input logic                 clk,
    input logic                 rst,
    message_slicer_fifo_if.slave bus
);
    localparam int DATA_W  = WIDTH * N_SLICES;
    localparam int LEN_W   = LOG_N_SLICES + 1;
    localparam int ENTRY_W = DATA_W + LEN_W;
    localparam int PTR_W   = LOG_BUFFER_LENGTH;
    localparam int FILL_W  = LOG_BUFFER_LENGTH + 1;

    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(N_SLICES);
    localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
    localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(BUFFER_LENGTH);
    localparam logic [LOG_N_SLICES-1:0] IDX_ZERO = {LOG_N_SLICES{1'b0}};
    localparam logic [LOG_N_SLICES-1:0] IDX_ONE  = {{(LOG_N_SLICES-1){1'b0}}, 1'b1};

    logic [ENTRY_W-1:0]      mem_q [BUFFER_LENGTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [LOG_N_SLICES-1:0] slice_idx_q, slice_idx_d;
    logic                    old_nd_q, old_nd_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    error_q, error_d;
    logic                    last_q, last_d;

    logic               toggle_s, len_bad_s, full_s, empty_s, wr_en_s;
    logic               load_s, pop_s, release_s;
    logic [ENTRY_W-1:0] rd_entry_s;
    logic [DATA_W-1:0]  rd_data_s;
    logic [LEN_W-1:0]   rd_len_s;
    logic [WIDTH-1:0]   slice_s;

    // Write/read qualifiers; fullness uses the start-of-cycle count so a same-cycle release cannot admit a write.
    always_comb begin
        toggle_s   = (bus.in_nd != old_nd_q);
        len_bad_s  = (bus.in_len == LEN_ZERO) || (bus.in_len > MAX_LEN);
        full_s     = (fill_q == FULL_LVL);
        empty_s    = (fill_q == FILL_ZERO);
        wr_en_s    = toggle_s && !len_bad_s && !full_s;
        rd_entry_s = mem_q[rd_ptr_q];
        rd_data_s  = rd_entry_s[ENTRY_W-1 -: DATA_W];
        rd_len_s   = rd_entry_s[LEN_W-1:0];
        slice_s    = rd_data_s[DATA_W-1 - int'(slice_idx_q)*WIDTH -: WIDTH];
        load_s     = !out_valid_q || bus.out_ready;
        pop_s      = load_s && !empty_s;
        release_s  = pop_s && ({1'b0, slice_idx_q} == (rd_len_s - LEN_ONE));
    end

    // Next-state logic for pointers, fill level, output register and sticky error.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        slice_idx_d = slice_idx_q;
        old_nd_d    = old_nd_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        error_d     = error_q;
        last_d      = last_q;

        if (toggle_s) begin
            old_nd_d = bus.in_nd;
            if (len_bad_s || full_s) begin
                error_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end else begin
            old_nd_d = old_nd_q;
        end

        if (pop_s) begin
            out_data_d  = slice_s;
            out_valid_d = 1'b1;
            last_d      = release_s;
            if (release_s) begin
                slice_idx_d = IDX_ZERO;
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
            end else begin
                slice_idx_d = slice_idx_q + IDX_ONE;
            end
        end else if (load_s) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case ({wr_en_s, release_s})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // Control and output state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            fill_q      <= FILL_ZERO;
            slice_idx_q <= IDX_ZERO;
            old_nd_q    <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            slice_idx_q <= slice_idx_d;
            old_nd_q    <= old_nd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
            last_q      <= last_d;
        end
    end

    // Word storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {bus.in_data, bus.in_len};
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fill_count = fill_q;
    assign bus.error      = error_q;
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
    assign bus.out_last   = last_q;
`endif

endmodule
